// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg7_pkg;

  // Scan FSM: all anodes off, or one digit lit.
  typedef enum logic {
    BLANK,
    ON
  } state_e;

  // Inputs captured once per frame so a frame is always self-consistent.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp_en;
    logic [3:0]  digit_en;
  } shadow_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage : seg7_pkg

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup into the shared pattern constant.
  assign seg_o = HEX_SEG[nibble_i];

endmodule : hex_to_seg7

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display,
// with a blanking gap before each digit and a once-per-frame input latch.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CNT_MAX0 = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
  localparam int unsigned CW       = $clog2(CNT_MAX);
  localparam bit          HAS_BLANK = (BLANK_CYCLES != 0);

  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam state_e        START_ST   = HAS_BLANK ? BLANK : ON;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  shadow_t       shadow_q, shadow_d;

  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          latch_c;
  logic [3:0]    nibble_c;
  logic [6:0]    hex_c;

  // Start of digit 0's slot opens a new frame: capture the inputs there.
  assign latch_c = (state_q == START_ST) && (idx_q == 2'd0) && (cnt_q == '0);

  // Next-state logic for the scan FSM, slot counter, digit index and shadow.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CW'(1);
    shadow_d = shadow_q;

    if (latch_c) begin
      shadow_d.value    = value;
      shadow_d.dp_en    = dp_en;
      shadow_d.digit_en = digit_en;
    end

    unique case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON: begin
        if (cnt_q == DIGIT_LAST) begin
          state_d = START_ST;
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = START_ST;
        cnt_d   = '0;
      end
    endcase
  end

  // Digit nibble selected from the upcoming index so outputs track the state edge.
  assign nibble_c = 4'(shadow_d.value >> {idx_d, 2'b00});

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (nibble_c),
    .seg_o    (hex_c)
  );

  // Output decode from the next state; registered below.
  always_comb begin
    an_d         = AN_OFF;
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;
    frame_done_d = 1'b0;

    if (state_d == ON && shadow_d.digit_en[idx_d]) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = hex_c;
      dp_d  = ~shadow_d.dp_en[idx_d];
    end

    if (state_d == ON && idx_d == 2'd3 && cnt_d == DIGIT_LAST) begin
      frame_done_d = 1'b1;
    end
  end

  // State, counter, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= START_ST;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule : seg7_scan_driver

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: one instance with a blank gap, one without.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic [3:0]  digit_en;

  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic        fd_a, fd_b;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .value      (value),
    .dp_en      (dp_en),
    .digit_en   (digit_en),
    .an         (an_a),
    .seg        (seg_a),
    .dp         (dp_a),
    .frame_done (fd_a)
  );

  seg7_scan_driver #(.DIGIT_CYCLES(4), .BLANK_CYCLES(0)) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .value      (value),
    .dp_en      (dp_en),
    .digit_en   (digit_en),
    .an         (an_b),
    .seg        (seg_b),
    .dp         (dp_b),
    .frame_done (fd_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // At most one anode may be driven in any cycle, on either instance.
  always @(negedge clk) begin
    check("one_anode_a", 32'($countones(~an_a) <= 1), 32'd1);
    check("one_anode_b", 32'($countones(~an_b) <= 1), 32'd1);
  end

  // Walks one 24-cycle frame of dut_a from its cycle 0, optionally changing inputs at chg_at.
  task automatic check_frame(input string tag,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] den, input logic [3:0] dpen,
                             input int chg_at, input logic [15:0] nv,
                             input logic [3:0] nden, input logic [3:0] ndpen);
    logic [6:0] segs [4];
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    int         slot;
    int         ph;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int c = 0; c < 24; c++) begin
      slot = c / 6;
      ph   = c % 6;
      if (ph < 2 || !den[slot]) begin
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
      end else begin
        ea = ~(4'b0001 << slot);
        es = segs[slot];
        ed = ~dpen[slot];
      end
      check({tag, "_an"},  32'(an_a),  32'(ea));
      check({tag, "_seg"}, 32'(seg_a), 32'(es));
      check({tag, "_dp"},  32'(dp_a),  32'(ed));
      check({tag, "_fd"},  32'(fd_a),  32'(c == 23));
      if (c == chg_at) begin
        value    = nv;
        digit_en = nden;
        dp_en    = ndpen;
      end
      tick();
    end
  endtask

  initial begin
    value    = 16'h1234;
    dp_en    = 4'h0;
    digit_en = 4'hF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an",  32'(an_a),  32'hF);
    check("rst_seg", 32'(seg_a), 32'h7F);
    check("rst_dp",  32'(dp_a),  32'h1);
    check("rst_fd",  32'(fd_a),  32'h0);

    // Release: this negedge precedes cycle 0.
    rst_a = 1'b0;
    check_frame("f1", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 4'h0, 8,  16'hABCD, 4'hF,    4'h0);
    check_frame("f2", 7'h21, 7'h46, 7'h03, 7'h08, 4'hF, 4'h0, 10, 16'hABCD, 4'b0101, 4'b0001);
    check_frame("f3", 7'h21, 7'h46, 7'h03, 7'h08, 4'b0101, 4'b0001, -1, 16'h0, 4'h0, 4'h0);

    // Run into digit 2's lit phase of the next frame, then pulse reset.
    repeat (14) tick();
    check("mid_d2_an",  32'(an_a),  32'hB);
    check("mid_d2_seg", 32'(seg_a), 32'h03);
    rst_a = 1'b1;
    tick();
    check("post_rst_an",  32'(an_a),  32'hF);
    check("post_rst_seg", 32'(seg_a), 32'h7F);
    check("post_rst_dp",  32'(dp_a),  32'h1);
    check("post_rst_fd",  32'(fd_a),  32'h0);
    rst_a = 1'b0;
    check("rel_c0_an", 32'(an_a), 32'hF);
    tick();
    check("rel_c1_an", 32'(an_a), 32'hF);
    tick();
    check("rel_c2_an",  32'(an_a),  32'hE);
    check("rel_c2_seg", 32'(seg_a), 32'h21);
    check("rel_c2_dp",  32'(dp_a),  32'h0);

    // No-blank instance: digits back to back, four cycles each.
    value    = 16'h1234;
    dp_en    = 4'h0;
    digit_en = 4'hF;
    rst_b    = 1'b0;
    check("nb_c0_an", 32'(an_b), 32'hF);
    for (int c = 1; c < 20; c++) begin
      logic [3:0] ea;
      int         d;
      tick();
      d  = (c / 4) % 4;
      ea = ~(4'b0001 << d);
      check("nb_an",  32'(an_b),  32'(ea));
      check("nb_seg", 32'(seg_b), 32'(seg_1234[d]));
      check("nb_dp",  32'(dp_b),  32'h1);
      check("nb_fd",  32'(fd_b),  32'(c == 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seg7_scan_driver
